// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, parity codes and frame geometry.
// The Rx deframe unit imports the same package.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned FRAME_LEN      = DATA_WIDTH_DEF + 3;

    // parity_type codes; 2'b11 also means no parity
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic int unsigned frame_len(input int unsigned data_width);
        return data_width + 3;
    endfunction

endpackage

// File: rtl/uart_tx_piso_if.sv
// Request/line bundle between the Tx control logic (master) and the PISO (slave).
interface uart_tx_piso_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  send;
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            parity_type;
    logic                  data_tx;
    logic                  active_flag;
    logic                  done_flag;

    modport master (
        output send, data_in, parity_type,
        input  data_tx, active_flag, done_flag
    );

    modport slave (
        input  send, data_in, parity_type,
        output data_tx, active_flag, done_flag
    );
endinterface

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for a data word; shared by the Tx framer and the Rx checker.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            parity_type_i,
    output logic                  parity_c_o
);

    // Odd: total ones including the parity bit is odd. None sends a 1.
    always_comb begin
        parity_c_o = 1'b1;
        case (parity_type_i)
            PAR_ODD:  parity_c_o = ~^data_i;
            PAR_EVEN: parity_c_o = ^data_i;
            default:  parity_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_piso.sv
// UART Tx parallel-in/serial-out: start, DATA_WIDTH bits LSB-first, parity, stop,
// one bit per baud_clk period; back-to-back frames when send is held at the end of stop.
module uart_tx_piso
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic          baud_clk,
    input  logic          reset_n,
    uart_tx_piso_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  active_q, active_d;
    logic                  done_q, done_d;
    logic                  par_c;
    logic                  load_c;

    // Parity is resolved at acceptance so later data_in changes cannot affect it.
    uart_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i        (bus.data_in),
        .parity_type_i (bus.parity_type),
        .parity_c_o    (par_c)
    );

    assign load_c = bus.send && ((state_q == IDLE) || (state_q == STOP));

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        tx_d     = tx_q;
        active_d = active_q;
        done_d   = 1'b0;

        // State names the bit currently on the line; each edge drives the next one.
        case (state_q)
            IDLE: begin
                tx_d     = 1'b1;
                active_d = 1'b0;
            end
            START: begin
                tx_d    = shift_q[0];
                shift_d = DATA_WIDTH'({1'b1, shift_q} >> 1);
                cnt_d   = CNT_W'(1);
                state_d = DATA;
            end
            DATA: begin
                if (cnt_q == CNT_W'(DATA_WIDTH)) begin
                    tx_d    = par_q;
                    state_d = PARITY;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = DATA_WIDTH'({1'b1, shift_q} >> 1);
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                tx_d    = 1'b1;
                state_d = STOP;
            end
            STOP: begin
                done_d   = 1'b1;
                tx_d     = 1'b1;
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                tx_d     = 1'b1;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // Accepting a request overrides the idle/stop exit and starts a new frame.
        if (load_c) begin
            shift_d  = bus.data_in;
            par_d    = par_c;
            cnt_d    = '0;
            tx_d     = 1'b0;
            active_d = 1'b1;
            state_d  = START;
        end
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '1;
            cnt_q    <= '0;
            par_q    <= 1'b1;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bus.data_tx     = tx_q;
    assign bus.active_flag = active_q;
    assign bus.done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Directed bench for uart_tx_piso: table of single frames, back-to-back, mid-frame send,
// mid-frame reset and a 16x-oversampled loopback capture.
module tb_uart_tx_piso;
    import uart_pkg::*;

    localparam int unsigned DW = 8;

    logic baud_clk = 1'b0;
    logic clk16    = 1'b0;
    logic reset_n;

    uart_tx_piso_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_piso #(.DATA_WIDTH(DW)) dut (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial forever #80 baud_clk = ~baud_clk;
    initial forever #5  clk16    = ~clk16;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Simple 16x oversampling receiver: detects the start edge and samples each bit mid-period.
    logic        rx_en;
    logic        rx_busy;
    logic        rx_done;
    logic [10:0] rx_frame;
    int          rx_tick;
    int          rx_idx;

    always @(posedge clk16) begin
        if (!rx_en) begin
            rx_busy <= 1'b0;
            rx_done <= 1'b0;
            rx_idx  <= 0;
            rx_tick <= 0;
        end else if (!rx_busy) begin
            if (!rx_done && bus.data_tx == 1'b0) begin
                rx_busy <= 1'b1;
                rx_tick <= 0;
                rx_idx  <= 0;
            end
        end else begin
            rx_tick <= rx_tick + 1;
            if ((rx_tick % 16) == 7) begin
                rx_frame[rx_idx] <= bus.data_tx;
                rx_idx <= rx_idx + 1;
                if (rx_idx == 10) begin
                    rx_busy <= 1'b0;
                    rx_done <= 1'b1;
                end
            end
        end
    end

    // Called just after a negedge with the DUT idle; ends two negedges after the done pulse.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] p,
                             input logic [10:0] exp, input string tag);
        logic [10:0] got;
        int          flag_bad;
        got      = '0;
        flag_bad = 0;
        bus.send        = 1'b1;
        bus.data_in     = d;
        bus.parity_type = p;
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            @(negedge baud_clk);
            if (i == 0) begin
                bus.send        = 1'b0;
                bus.data_in     = ~d;
                bus.parity_type = ~p;
            end
            got[i] = bus.data_tx;
            if (bus.active_flag !== 1'b1 || bus.done_flag !== 1'b0) flag_bad++;
        end
        check({tag, " frame"}, 32'(got), 32'(exp));
        check({tag, " flags_in_frame"}, 32'(flag_bad), 32'd0);
        @(negedge baud_clk);
        check({tag, " end_done_act_line"},
              32'({bus.done_flag, bus.active_flag, bus.data_tx}), 32'b101);
        @(negedge baud_clk);
        check({tag, " done_one_cycle"}, 32'(bus.done_flag), 32'd0);
    endtask

    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  ptype;
        logic [10:0] frame;
    } vec_t;

    vec_t        vecs [10];
    logic [10:0] f1, f2, got4;
    logic        exp_line;
    int          bad_line, bad_done, bad_act, dones;

    initial begin
        // frame bit i = line value after edge Ei: {stop, parity, data[7:0], start}
        vecs[0] = '{8'hA5, PAR_EVEN, 11'b1_0_10100101_0};
        vecs[1] = '{8'hA5, PAR_ODD,  11'b1_1_10100101_0};
        vecs[2] = '{8'hA5, PAR_NONE, 11'b1_1_10100101_0};
        vecs[3] = '{8'hA5, 2'b11,    11'b1_1_10100101_0};
        vecs[4] = '{8'h07, PAR_EVEN, 11'b1_1_00000111_0};
        vecs[5] = '{8'h07, PAR_ODD,  11'b1_0_00000111_0};
        vecs[6] = '{8'h00, PAR_EVEN, 11'b1_0_00000000_0};
        vecs[7] = '{8'h00, PAR_ODD,  11'b1_1_00000000_0};
        vecs[8] = '{8'hFF, PAR_EVEN, 11'b1_0_11111111_0};
        vecs[9] = '{8'h80, PAR_ODD,  11'b1_0_10000000_0};

        reset_n         = 1'b0;
        rx_en           = 1'b0;
        bus.send        = 1'b0;
        bus.data_in     = '0;
        bus.parity_type = PAR_NONE;
        repeat (2) @(negedge baud_clk);
        check("reset_line_act_done",
              32'({bus.data_tx, bus.active_flag, bus.done_flag}), 32'b100);
        reset_n = 1'b1;
        @(negedge baud_clk);
        check("idle_after_reset",
              32'({bus.data_tx, bus.active_flag, bus.done_flag}), 32'b100);

        for (int v = 0; v < 10; v++)
            run_frame(vecs[v].data, vecs[v].ptype, vecs[v].frame, $sformatf("vec%0d", v));

        // Back-to-back: send held, 8'h00 then 8'hFF, even parity
        f1 = 11'b1_0_00000000_0;
        f2 = 11'b1_0_11111111_0;
        bad_line = 0; bad_done = 0; bad_act = 0;
        bus.send        = 1'b1;
        bus.data_in     = 8'h00;
        bus.parity_type = PAR_EVEN;
        for (int i = 0; i <= 22; i++) begin
            @(negedge baud_clk);
            if (i == 0)  bus.data_in = 8'hFF;
            if (i == 11) bus.send    = 1'b0;
            exp_line = (i < 11) ? f1[i] : ((i < 22) ? f2[i-11] : 1'b1);
            if (bus.data_tx !== exp_line) bad_line++;
            if (bus.done_flag !== ((i == 11) || (i == 22))) bad_done++;
            if (bus.active_flag !== (i < 22)) bad_act++;
        end
        check("b2b line", 32'(bad_line), 32'd0);
        check("b2b done", 32'(bad_done), 32'd0);
        check("b2b active", 32'(bad_act), 32'd0);
        @(negedge baud_clk);

        // send pulsed at E4 with other data: ignored
        got4 = '0;
        bus.send        = 1'b1;
        bus.data_in     = 8'hA5;
        bus.parity_type = PAR_EVEN;
        for (int i = 0; i < 11; i++) begin
            @(negedge baud_clk);
            if (i == 0) bus.send = 1'b0;
            if (i == 3) begin
                bus.send        = 1'b1;
                bus.data_in     = 8'h5A;
                bus.parity_type = PAR_ODD;
            end
            if (i == 4) bus.send = 1'b0;
            got4[i] = bus.data_tx;
        end
        check("midsend frame", 32'(got4), 32'(11'b1_0_10100101_0));
        dones = 0; bad_line = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge baud_clk);
            if (bus.done_flag === 1'b1) dones++;
            if (bus.data_tx !== 1'b1) bad_line++;
        end
        check("midsend done_count", 32'(dones), 32'd1);
        check("midsend idle_line", 32'(bad_line), 32'd0);

        // Reset asserted mid-frame (during bit 4)
        bus.send        = 1'b1;
        bus.data_in     = 8'hC3;
        bus.parity_type = PAR_EVEN;
        for (int i = 0; i < 5; i++) begin
            @(negedge baud_clk);
            if (i == 0) bus.send = 1'b0;
        end
        check("prereset active", 32'(bus.active_flag), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset line_act_done",
              32'({bus.data_tx, bus.active_flag, bus.done_flag}), 32'b100);
        @(negedge baud_clk);
        reset_n = 1'b1;
        dones = 0; bad_act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge baud_clk);
            if (bus.done_flag === 1'b1) dones++;
            if (bus.active_flag !== 1'b0 || bus.data_tx !== 1'b1) bad_act++;
        end
        check("postreset no_done", 32'(dones), 32'd0);
        check("postreset idle", 32'(bad_act), 32'd0);
        run_frame(8'hC3, PAR_EVEN, 11'b1_0_11000011_0, "postreset");

        // Loopback through the 16x receiver
        rx_en = 1'b1;
        @(negedge baud_clk);
        run_frame(8'h3C, PAR_EVEN, 11'b1_0_00111100_0, "loopback_tx");
        for (int k = 0; k < 400 && rx_done !== 1'b1; k++) @(negedge clk16);
        check("loopback rx_done", 32'(rx_done), 32'd1);
        check("loopback rx_frame", 32'(rx_frame), 32'(11'b1_0_00111100_0));
        rx_en = 1'b0;
        @(negedge baud_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
